// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter / run-control stage.
package pc_ctrl_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int BR_W_DEF  = 8;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and run control: start/halt sequencing, branch target
// arithmetic and a saturating RUN-cycle counter.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int BR_W  = BR_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [PC_W-1:0]  START_ADDR,
  input  logic             STALL,
  input  logic             BR_EN,
  input  logic [BR_W-1:0]  bOFFSET,
  input  logic             bSIGN,
  input  logic             SOFT_RST,
  input  logic             HALT,
  output logic [PC_W-1:0]  PC,
  output logic             INSTR_VALID,
  output logic             DONE,
  output logic [CYC_W-1:0] CYCLES
);

  pc_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [PC_W-1:0] r_start_addr, w_start_nxt;
  logic [PC_W-1:0] w_off;
  logic            r_done, w_done_nxt;
  logic            w_launch, w_go, w_running;

  assign w_running = (r_state == RUN);
  assign w_launch  = !w_running && START;
  assign w_go      = w_running && !STALL;
  assign w_off     = PC_W'(bOFFSET);

  // NOTE: the async reset clears only the control flops; this block has no memories to reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, HALTED: if (START) w_state_nxt = RUN;
      RUN:          if (w_go && SOFT_RST && HALT) w_state_nxt = HALTED;
      default:      w_state_nxt = IDLE;
    endcase
  end

  // Datapath next values; the branch target wraps modulo 2^PC_W by construction.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_start_nxt = r_start_addr;
    w_done_nxt  = r_done;
    if (w_launch) begin
      w_pc_nxt    = START_ADDR;
      w_start_nxt = START_ADDR;
      w_done_nxt  = 1'b0;
    end else if (w_go) begin
      if (SOFT_RST) begin
        if (HALT) w_done_nxt = 1'b1;
        else      w_pc_nxt   = r_start_addr;
      end else if (BR_EN) begin
        w_pc_nxt = bSIGN ? (r_pc - w_off) : (r_pc + w_off);
      end else begin
        w_pc_nxt = r_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc         <= '0;
      r_start_addr <= '0;
      r_done       <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_start_addr <= w_start_nxt;
      r_done       <= w_done_nxt;
    end
  end

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_en    (w_running),
    .i_clr   (w_launch),
    .o_count (CYCLES)
  );

  assign PC          = r_pc;
  assign DONE        = r_done;
  assign INSTR_VALID = w_go;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a driver pushes model predictions, a monitor
// pops and compares them on the falling edge.
module tb_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int BR_W  = 8;
  localparam int CYC_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             START = 1'b0;
  logic [PC_W-1:0]  START_ADDR = '0;
  logic             STALL = 1'b0;
  logic             BR_EN = 1'b0;
  logic [BR_W-1:0]  bOFFSET = '0;
  logic             bSIGN = 1'b0;
  logic             SOFT_RST = 1'b0;
  logic             HALT = 1'b0;
  logic [PC_W-1:0]  PC;
  logic             INSTR_VALID;
  logic             DONE;
  logic [CYC_W-1:0] CYCLES;

  pc_ctrl #(.PC_W(PC_W), .BR_W(BR_W), .CYC_W(CYC_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .START_ADDR(START_ADDR),
    .STALL(STALL), .BR_EN(BR_EN), .bOFFSET(bOFFSET), .bSIGN(bSIGN),
    .SOFT_RST(SOFT_RST), .HALT(HALT), .PC(PC), .INSTR_VALID(INSTR_VALID),
    .DONE(DONE), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pc;
    bit done;
    bit valid;
    int cyc;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: run flag, current address, entry address, halt flag, cycle count.
  bit m_run, m_done;
  int m_pc, m_entry, m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_entry = 0; m_cyc = 0;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input bit start, input int addr, input bit stall, input bit br,
                      input int off, input bit sgn, input bit srst, input bit halt);
    exp_t e;
    START = start; START_ADDR = PC_W'(addr); STALL = stall; BR_EN = br;
    bOFFSET = BR_W'(off); bSIGN = sgn; SOFT_RST = srst; HALT = halt;
    e.pc = m_pc; e.done = m_done; e.cyc = m_cyc; e.valid = m_run && !stall;
    q_exp.push_back(e);
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_pc = addr; m_entry = addr; m_cyc = 0;
      end
    end else begin
      if (m_cyc < CYC_MAX) m_cyc++;
      if (!stall) begin
        if (srst && halt)  begin m_run = 0; m_done = 1; end
        else if (srst)     m_pc = m_entry;
        else if (br)       m_pc = sgn ? (m_pc + PC_MOD - (off % PC_MOD)) % PC_MOD
                                      : (m_pc + off) % PC_MOD;
        else               m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic branch(input int off, input bit sgn);
    step(0, 0, 0, 1, off, sgn, 0, 0);
  endtask

  task automatic launch(input int addr);
    step(1, addr, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset(input string tag);
    START = 0; STALL = 0; BR_EN = 0; SOFT_RST = 0; HALT = 0;
    RESET_N = 1'b0;
    #1;
    check({tag, "_pc"},    32'(PC), 32'h0);
    check({tag, "_done"},  32'(DONE), 32'h0);
    check({tag, "_valid"}, 32'(INSTR_VALID), 32'h0);
    check({tag, "_cyc"},   32'(CYCLES), 32'h0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      check("sb_pc",    32'(PC), 32'(e.pc));
      check("sb_done",  32'(DONE), 32'(e.done));
      check("sb_valid", 32'(INSTR_VALID), 32'(e.valid));
      check("sb_cyc",   32'(CYCLES), 32'(e.cyc));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pc",    32'(PC), 32'h0);
    check("rst_done",  32'(DONE), 32'h0);
    check("rst_valid", 32'(INSTR_VALID), 32'h0);
    check("rst_cyc",   32'(CYCLES), 32'h0);
    RESET_N = 1'b1;
    plain(2);

    // Reset in the middle of a run
    launch('h050);
    plain(5);
    check("t1_pc055", 32'(PC), 32'h055);
    async_reset("t1");

    // Launch and sequential stepping
    launch('h010);
    check("t2_pc010", 32'(PC), 32'h010);
    check("t2_cyc0",  32'(CYCLES), 32'h0);
    plain(3);
    check("t2_pc013", 32'(PC), 32'h013);
    check("t2_cyc3",  32'(CYCLES), 32'h3);

    // Branches, including the zero-offset self-loop
    branch('h0D, 0); check("t3_pc020", 32'(PC), 32'h020);
    branch(5, 1);    check("t3_pc01b", 32'(PC), 32'h01B);
    branch(1, 0);    check("t3_pc01c", 32'(PC), 32'h01C);
    branch(0, 0);    check("t3_self",  32'(PC), 32'h01C);

    // Wrap in both directions
    branch('h1E, 1); check("t4_pc3fe", 32'(PC), 32'h3FE);
    branch(4, 0);    check("t4_wrapf", 32'(PC), 32'h002);
    branch(1, 1);    check("t4_pc001", 32'(PC), 32'h001);
    branch(3, 1);    check("t4_wrapb", 32'(PC), 32'h3FE);

    // Halt, frozen counters, restart, soft reset to entry
    branch('h32, 0); check("t5_pc030", 32'(PC), 32'h030);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("t5_done",  32'(DONE), 32'h1);
    check("t5_pchld", 32'(PC), 32'h030);
    plain(10);
    check("t5_cycfrz", 32'(CYCLES), 32'(m_cyc));
    check("t5_donehld", 32'(DONE), 32'h1);
    launch('h000);
    check("t5_restart_done", 32'(DONE), 32'h0);
    check("t5_restart_pc",   32'(PC), 32'h000);
    branch('h40, 0); check("t5_pc040", 32'(PC), 32'h040);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_softrst", 32'(PC), 32'h000);

    // Stall masks every strobe while the counter keeps running
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 7, 0, 1, 1);
    check("t6_stall_pc",   32'(PC), 32'h000);
    check("t6_stall_done", 32'(DONE), 32'h0);
    check("t6_stall_cyc",  32'(CYCLES), 32'(m_cyc));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, PC_MOD - 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 255), $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    // Long run to drive the cycle counter into saturation
    async_reset("t6");
    launch('h100);
    for (int i = 0; i < CYC_MAX + 6; i++) begin
      step(0, 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 255), $urandom_range(0, 1) == 1, 0, 0);
    end
    check("t6_sat", 32'(CYCLES), 32'hFFFF);

    START = 0; STALL = 0; BR_EN = 0; SOFT_RST = 0; HALT = 0;
    @(negedge CLK);
    #1;
    check("sb_drained", 32'(q_exp.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
